// File: rtl/cfg_pkg.sv
// Shared types and CRC constants for the configuration chain loader.
// The CRC step is used both by the serial CRC block and by the verify compare.
package cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One bit of CCITT CRC-16, MSB-out, unreflected.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16 accumulator with synchronous clear; advances only when en is high.
module crc16_serial
    import cfg_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc16_step(crc_q, din);
        end
    end

    always_ff @(posedge clk) begin
        crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/cfg_loader.sv
// Serializes a word stream onto the fabric programming chain and optionally
// rotates the chain once to compare a readback CRC against the load CRC.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for start after reset
// ST_LOAD   | accepting words and shifting bits into the chain
// ST_VERIFY | rotating the chain CHAIN_LEN cycles, accumulating readback CRC
// ST_DONE   | load (and verify) completed cleanly; waits for next start
// ST_ERROR  | readback CRC differed from load CRC; waits for next start
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 512,
    parameter int WORD_W    = 16
) (
    input  logic              prog_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              chain_out,
    output logic              prog_en,
    output logic              prog_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       crc
);

    localparam int CW      = $clog2(CHAIN_LEN + 1);
    localparam int SW      = $clog2(WORD_W + 1);
    localparam int N_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;

    localparam logic [CW-1:0] LEN_C   = CW'(CHAIN_LEN);
    localparam logic [CW-1:0] LAST_C  = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] WORDS_C = CW'(N_WORDS);
    localparam logic [SW-1:0] WBITS_C = SW'(WORD_W);

    state_t              state_q, state_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]       word_cnt_q, word_cnt_d;
    logic [CW-1:0]       vcnt_q, vcnt_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [SW-1:0]       shift_cnt_q, shift_cnt_d;
    logic [WORD_W-1:0]   hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic                verify_q, verify_d;
    logic                prog_en_q, prog_en_d;
    logic                prog_in_q, prog_in_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                start_acc;
    logic                accept;
    logic                emit;
    logic [WORD_W-1:0]   src_word;
    logic [SW-1:0]       src_cnt;
    logic                src_ok;
    logic                src_hold;
    logic                src_in;
    logic                crc_clr;
    logic                rb_en;
    logic [15:0]         load_crc;
    logic [15:0]         rb_crc;
    logic                rb_match;

    assign start_acc = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
    assign cfg_ready = (state_q == ST_LOAD) && !hold_full_q && (word_cnt_q < WORDS_C);
    assign accept    = cfg_valid && cfg_ready;

    // Bit source priority: shift word, then holding register, then the word arriving now.
    always_comb begin
        src_word = shift_q;
        src_cnt  = shift_cnt_q;
        src_ok   = 1'b0;
        src_hold = 1'b0;
        src_in   = 1'b0;
        if (shift_cnt_q != '0) begin
            src_ok = 1'b1;
        end else if (hold_full_q) begin
            src_word = hold_q;
            src_cnt  = WBITS_C;
            src_ok   = 1'b1;
            src_hold = 1'b1;
        end else if (accept) begin
            src_word = cfg_data;
            src_cnt  = WBITS_C;
            src_ok   = 1'b1;
            src_in   = 1'b1;
        end
    end

    assign emit     = (state_q == ST_LOAD) && src_ok && (bit_cnt_q < LEN_C);
    assign rb_en    = (state_q == ST_VERIFY);
    assign crc_clr  = rst || start_acc;
    assign rb_match = (crc16_step(rb_crc, chain_out) == load_crc);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        vcnt_d      = vcnt_q;
        shift_d     = shift_q;
        shift_cnt_d = shift_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        verify_d    = verify_q;
        prog_en_d   = 1'b0;
        prog_in_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    bit_cnt_d   = '0;
                    word_cnt_d  = '0;
                    shift_cnt_d = '0;
                    hold_full_d = 1'b0;
                    verify_d    = verify_en;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                end
            end
            ST_LOAD: begin
                prog_en_d = emit;
                prog_in_d = emit && src_word[0];
                if (emit) begin
                    shift_d     = src_word >> 1;
                    shift_cnt_d = src_cnt - SW'(1);
                    bit_cnt_d   = bit_cnt_q + CW'(1);
                    if (src_hold) begin
                        hold_full_d = 1'b0;
                    end
                end
                if (accept) begin
                    word_cnt_d = word_cnt_q + CW'(1);
                    if (!src_in) begin
                        hold_d      = cfg_data;
                        hold_full_d = 1'b1;
                    end
                end
                // Last bit is on prog_en_q this cycle; leave LOAD after it shifts.
                if (bit_cnt_q == LEN_C) begin
                    if (verify_q) begin
                        state_d = ST_VERIFY;
                        vcnt_d  = LAST_C;
                    end else begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_VERIFY: begin
                if (vcnt_q == '0) begin
                    busy_d = 1'b0;
                    if (rb_match) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end
                end else begin
                    vcnt_d = vcnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            vcnt_q      <= '0;
            shift_q     <= '0;
            shift_cnt_q <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            verify_q    <= 1'b0;
            prog_en_q   <= 1'b0;
            prog_in_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            vcnt_q      <= vcnt_d;
            shift_q     <= shift_d;
            shift_cnt_q <= shift_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            verify_q    <= verify_d;
            prog_en_q   <= prog_en_d;
            prog_in_q   <= prog_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    crc16_serial u_load_crc (
        .clk (prog_clk),
        .clr (crc_clr),
        .en  (emit),
        .din (src_word[0]),
        .crc (load_crc)
    );

    crc16_serial u_rb_crc (
        .clk (prog_clk),
        .clr (crc_clr),
        .en  (rb_en),
        .din (chain_out),
        .crc (rb_crc)
    );

    // During verify the chain output loops straight back to its input.
    assign prog_en = prog_en_q || (state_q == ST_VERIFY);
    assign prog_in = (state_q == ST_VERIFY) ? chain_out : prog_in_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;
    assign crc     = load_crc;

endmodule

// File: doc/cfg_loader.md
# cfg_loader

Configuration controller for the fabric programming chain. Accepts the bitstream as parallel words over a valid/ready stream and serializes it onto the daisy-chained `prog_in`/`prog_en` shift path through the CB, CLB and SB tiles, all clocked by `prog_clk`. After loading, it can optionally recirculate the chain to read back its contents non-destructively. It then checks the readback CRC-16 against the load CRC and reports done or error.

## Interface
Parameters:
- `CHAIN_LEN`, default 512: total configuration bits in the chain (sum of all tile shift registers); range 2..65535.
- `WORD_W`, default 16: input word width; range 1..32.

Ports:
- `prog_clk`  in  1  programming clock; sole clock of this block.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE, DONE and ERROR.
- `verify_en`  in  1  sampled together with `start`; 1 adds the readback pass.
- `cfg_data`  in  WORD_W  bitstream word, sent LSB-first.
- `cfg_valid`  in  1  `cfg_data` valid.
- `cfg_ready`  out  1  word accepted on a cycle when `cfg_valid & cfg_ready`.
- `chain_out`  in  1  `prog_out` of the last tile in the chain.
- `prog_en`  out  1  chain shift enable.
- `prog_in`  out  1  serial data into the first tile.
- `busy`  out  1  high in LOAD and VERIFY.
- `done`  out  1  level; the load completed with no error.
- `error`  out  1  level; readback CRC mismatch.
- `crc`  out  16  CRC-16 of the loaded bits.

## Operation
- States: IDLE, LOAD, VERIFY, DONE, ERROR.
- IDLE/DONE/ERROR + `start` → LOAD.
  - Clears the bit counter, the word count, the holding register, `done`, `error`, and both CRCs (set to 0xFFFF).
  - Latches `verify_en`.
- LOAD datapath:
  - Two-stage buffer: a shift word and a one-word holding register.
  - `cfg_ready` = holding register empty AND accepted words < ceil(CHAIN_LEN/WORD_W).
  - When the shift word is exhausted and the holding register is full, the holding register moves to the shift word on the same cycle, so there is no bubble.
- LOAD output, each cycle with a bit available: `prog_en`=1, `prog_in`=current bit, and the bit counter increments.
  - With no bit available: `prog_en`=0 and the chain holds its contents.
- The first bit sent ends at the far end of the chain; it is the first bit `chain_out` presents once the load completes.
- On a partial final word, bits beyond `CHAIN_LEN` are discarded and never shifted.
- After bit `CHAIN_LEN-1` is shifted: if `verify_en` was latched, go to VERIFY, otherwise go to DONE.
- VERIFY runs exactly `CHAIN_LEN` cycles.
  - `prog_en`=1 and `prog_in`=`chain_out`, combinationally, so the chain rotates back to its original contents.
  - `chain_out` is fed into the readback CRC on each of those cycles.
- VERIFY end: readback CRC == load CRC → DONE, else → ERROR.
- CRC: CCITT, polynomial 0x1021, init 0xFFFF, bit-serial, MSB-out, no reflection, no final XOR. It updates only on cycles where a bit is actually shifted.
- `start` while `busy` is ignored.
- `cfg_valid` in any state other than LOAD is ignored (`cfg_ready`=0).
- `done`/`error` hold until the next accepted `start` or `rst`.

## Timing
- Reset values: `prog_en`=0, `prog_in`=0, `cfg_ready`=0, `busy`=0, `done`=0, `error`=0, `crc`=0xFFFF; state=IDLE.
- `rst` during LOAD or VERIFY:
  - `prog_en`=0 from the next edge.
  - Chain contents are undefined.
  - No `done`/`error` is raised.
- Latencies:
  - `start` → `busy`=1 next cycle.
  - First accepted word → first `prog_en` on the following cycle.
  - `prog_en` and `prog_in` are registered in LOAD.
- Throughput: with `cfg_valid` held high, `prog_en` stays high for exactly `CHAIN_LEN` consecutive LOAD cycles.
- Duration with verify: `prog_en` is high for exactly `CHAIN_LEN` consecutive cycles after the LOAD→VERIFY transition, with no gap cycle between LOAD and VERIFY.
- `done`/`error` assert one cycle after the final shifted bit; `busy` falls on the same cycle.
- `crc` is valid whenever `busy`=0.

## Structure
- Shared package `cfg_pkg`: state enum, `CRC_POLY`=16'h1021, `CRC_INIT`=16'hFFFF.
- Sub-module `crc16_serial` (inputs: clk, synchronous clear, enable, data bit; output: crc), instantiated twice (load and readback).
- The bit and word counters are sized with `$clog2` of `CHAIN_LEN+1`.

## Test plan
- CHAIN_LEN=20, WORD_W=16, behavioral 20-bit chain model; two words with `cfg_valid` held high, `verify_en`=0 → `prog_en` high 20 consecutive cycles, chain holds the expected image, `done`=1, `error`=0.
- Same setup with `verify_en`=1 → 20 recirculation cycles, chain image unchanged afterwards, `done`=1, `crc` equals the reference CRC of the 20 bits.
- Verify pass with one chain bit forced flipped between LOAD and VERIFY → `error`=1, `done`=0.
- `cfg_valid` toggling every other cycle → `prog_en` low on starved cycles, final image correct; word beyond the count is never accepted (`cfg_ready`=0).
- `rst` asserted at bit 10 of LOAD → next cycle `prog_en`=0, `busy`=0, `done`=0; a subsequent `start` completes normally.
- `start` pulsed mid-LOAD → ignored; bit count and final image unchanged.
